// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Radix-2 shift-add multiplier, signed/unsigned, fixed latency
//                of WIDTH+1 cycles with valid/ready handshakes on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 sgn,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     mcand, mplier;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   acc, acc_nxt, prod_fin;
   logic [WIDTH:0]       sum;
   logic [CW-1:0]        cnt;
   logic                 neg;
   logic                 accept;
   logic                 last;

   // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned
   always_comb begin
      a_mag = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   end

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
      acc_nxt  = {sum, acc[WIDTH-1:1]};
      prod_fin = neg ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
      last     = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nxt = CALC;
         end
         CALC: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         p      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            CALC: begin
               acc    <= acc_nxt;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last) p <= prod_fin;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Self-checking bench for seq_multiplier at WIDTH=4 and 16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv4, ir4, s4, ov4, or4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        iv16, ir16, s16, ov16, or16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int checks   = 0;
   int failures = 0;

   seq_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .sgn(s4), .out_valid(ov4), .out_ready(or4), .p(p4));

   seq_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .sgn(s16), .out_valid(ov16), .out_ready(or16), .p(p16));

   function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
      longint m, n;
      if (s) begin m = $signed(x); n = $signed(y); end
      else   begin m = x;          n = y;          end
      return 8'(m * n);
   endfunction

   function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
      longint m, n;
      if (s) begin m = $signed(x); n = $signed(y); end
      else   begin m = x;          n = y;          end
      return 32'(m * n);
   endfunction

   // Runs one operation; outputs are judged by the calling test
   task automatic op4(input logic [3:0] oa, input logic [3:0] ob, input logic os, input int stall,
                      output logic [7:0] prod, output int lat, output bit hold_ok);
      int n = 0;
      hold_ok = 1'b1;
      iv4 = 1'b1; a4 = oa; b4 = ob; s4 = os;
      while (!ir4 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
      lat = 0;
      while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
      prod = p4;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (p4 !== prod || ov4 !== 1'b1 || ir4 !== 1'b0) hold_ok = 1'b0;
      end
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
      if (ov4 !== 1'b0 || ir4 !== 1'b1) hold_ok = 1'b0;
   endtask

   task automatic op16(input logic [15:0] oa, input logic [15:0] ob, input logic os, input int stall,
                       output logic [31:0] prod, output int lat);
      int n = 0;
      iv16 = 1'b1; a16 = oa; b16 = ob; s16 = os;
      while (!ir16 && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
      lat = 0;
      while (!ov16 && lat < 60) begin @(posedge clk); #1; lat++; end
      prod = p16;
      repeat (stall) begin @(posedge clk); #1; end
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; iv4 = 1'b1; or4 = 1'b1; iv16 = 1'b1; or16 = 1'b1;
      a4 = 4'hF; b4 = 4'hF; s4 = 1'b0; a16 = '1; b16 = '1; s16 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      iv4 = 1'b0; or4 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
      checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir4); end
      checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
      checks++; if (p4 !== 8'h00) begin failures++; $display("FAIL reset_p got=%h exp=00", p4); end
      checks++; if (p16 !== 32'h0) begin failures++; $display("FAIL reset_p16 got=%h exp=0", p16); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", ir4); end
   endtask

   task automatic test_vectors();
      logic [7:0] pr; int lat; bit ok;
      logic [3:0] va [4] = '{4'hF, 4'h8, 4'hD, 4'h0};
      logic [3:0] vb [4] = '{4'hF, 4'h8, 4'h5, 4'h8};
      logic       vs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] vp [4] = '{8'hE1, 8'h40, 8'hF1, 8'h00};
      for (int i = 0; i < 4; i++) begin
         op4(va[i], vb[i], vs[i], 0, pr, lat, ok);
         checks++;
         if (pr !== vp[i]) begin
            failures++; $display("FAIL vector%0d_p got=%h exp=%h", i, pr, vp[i]);
         end
         checks++;
         if (lat !== 4) begin failures++; $display("FAIL vector%0d_latency got=%0d exp=4", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] pr; int lat; bit ok;
      op4(4'h7, 4'h6, 1'b0, 3, pr, lat, ok);
      checks++; if (pr !== 8'd42) begin failures++; $display("FAIL bp_p got=%h exp=2a", pr); end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b exp=1", ok); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] pr; int lat; bit ok; bit seen = 1'b0;
      op4(4'hF, 4'hF, 1'b0, 0, pr, lat, ok);
      iv4 = 1'b1; a4 = 4'h9; b4 = 4'hB; s4 = 1'b0;
      @(posedge clk); #1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (ir4 !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", ir4); end
      checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", ov4); end
      checks++; if (p4 !== 8'h00) begin failures++; $display("FAIL midrst_p got=%h exp=00", p4); end
      repeat (8) begin @(posedge clk); #1; if (ov4 !== 1'b0) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_stale_valid got=%b exp=0", seen); end
      op4(4'h7, 4'h3, 1'b0, 1, pr, lat, ok);
      checks++; if (pr !== 8'd21) begin failures++; $display("FAIL midrst_next_p got=%h exp=15", pr); end
   endtask

   task automatic test_back_to_back();
      int first = -1, second = -1;
      logic [7:0] p1 = 8'h00, p2 = 8'h00;
      iv4 = 1'b1; a4 = 4'hD; b4 = 4'h5; s4 = 1'b1; or4 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (ov4 === 1'b1) begin
            if (first < 0) begin first = c; p1 = p4; end
            else if (second < 0) begin second = c; p2 = p4; end
         end
      end
      iv4 = 1'b0;
      repeat (8) @(posedge clk);
      #1; or4 = 1'b0;
      checks++; if (second - first !== 6) begin
         failures++; $display("FAIL b2b_interval got=%0d exp=6", second - first); end
      checks++; if (p1 !== 8'hF1) begin failures++; $display("FAIL b2b_p1 got=%h exp=f1", p1); end
      checks++; if (p2 !== 8'hF1) begin failures++; $display("FAIL b2b_p2 got=%h exp=f1", p2); end
   endtask

   task automatic test_exhaustive4();
      logic [7:0] pr, ex; int lat; bit ok;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
               op4(4'(i), 4'(j), 1'(s), int'($urandom_range(0, 2)), pr, lat, ok);
               ex = ref4(4'(i), 4'(j), 1'(s));
               checks++;
               if (pr !== ex) begin
                  failures++; $display("FAIL exh4_p a=%h b=%h s=%0d got=%h exp=%h", i, j, s, pr, ex);
               end
               checks++;
               if (lat !== 4 || ok !== 1'b1) begin
                  failures++; $display("FAIL exh4_timing a=%h b=%h lat=%0d hold=%b exp lat=4 hold=1", i, j, lat, ok);
               end
            end
   endtask

   task automatic test_width16();
      logic [31:0] pr, ex; int lat;
      logic [15:0] cv [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000};
      logic [15:0] xa, xb; logic xs;
      for (int k = 0; k < 332; k++) begin
         if (k < 32) begin xa = cv[k % 4]; xb = cv[(k / 4) % 4]; xs = 1'(k / 16); end
         else begin xa = 16'($urandom); xb = 16'($urandom); xs = 1'($urandom); end
         op16(xa, xb, xs, int'($urandom_range(0, 2)), pr, lat);
         ex = ref16(xa, xb, xs);
         checks++;
         if (pr !== ex) begin
            failures++; $display("FAIL w16_p a=%h b=%h s=%0d got=%h exp=%h", xa, xb, xs, pr, ex);
         end
         checks++;
         if (lat !== 16) begin failures++; $display("FAIL w16_latency got=%0d exp=16", lat); end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_exhaustive4();
      test_width16();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
